// File: rtl/ingress_arb_pkg.sv
// rtl/ingress_arb_pkg.sv - shared types and round-robin pick helper for the ingress port arbiter
package ingress_arb_pkg;

    localparam int MAX_PORTS = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RELOAD,
        BUSY
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Rotate so last_ptr+1 sits at bit 0, take the lowest set bit, then rotate the index back.
    // Unused upper ports are zero, so wrapping at MAX_PORTS equals wrapping at the real port count.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] elig,
                                         input logic [MAX_IDX_W-1:0] last_ptr);
        logic [MAX_IDX_W-1:0] start;
        logic [MAX_PORTS-1:0] rot;
        rr_pick_t             r;
        start   = last_ptr + 4'd1;
        rot     = MAX_PORTS'({elig, elig} >> start);
        r.found = |elig;
        r.idx   = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) r.idx = MAX_IDX_W'(i);
        end
        r.idx = r.idx + start;
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin first-eligible picker starting after last_ptr
module rr_priority_pick
    import ingress_arb_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] last_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_PORTS'(elig), MAX_IDX_W'(last_ptr));
        found = pick.found;
        idx   = IDX_W'(pick.idx);
    end

endmodule

// File: rtl/ingress_port_arbiter.sv
// rtl/ingress_port_arbiter.sv - packet-granular weighted round-robin arbiter; optional stats via INGRESS_ARB_STATS_EN
module ingress_port_arbiter
    import ingress_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int WEIGHT_W  = 4,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] cfg_weight,
    input  logic                          m_fire,
    input  logic                          m_last,
`ifdef INGRESS_ARB_STATS_EN
    input  logic                          stat_clear,
    output logic [NUM_PORTS*32-1:0]       stat_pkt_cnt,
    output logic                          stat_proto_err,
`endif
    output logic [NUM_PORTS-1:0]          grant,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          round_start
);

    arb_state_e           state, state_nxt;
    logic [WEIGHT_W-1:0]  credit [NUM_PORTS];
    logic [IDX_W-1:0]     last_ptr;
    logic [NUM_PORTS-1:0] elig;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pkt_done;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req[i] & (credit[i] != '0);
        end
    end

    rr_priority_pick #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig     (elig),
        .last_ptr (last_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign pkt_done    = (state == BUSY) && m_fire && m_last;
    assign grant_valid = |grant;
    assign round_start = (state == RELOAD);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nxt = pick_found ? BUSY : RELOAD;
                end
            end
            RELOAD:  state_nxt = IDLE;
            BUSY:    if (pkt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            last_ptr  <= IDX_W'(NUM_PORTS - 1);
            for (int i = 0; i < NUM_PORTS; i++) credit[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == BUSY) begin
                grant     <= NUM_PORTS'(1) << pick_idx;
                grant_idx <= pick_idx;
                last_ptr  <= pick_idx;
            end
            // Weight 0 would starve a port forever, so it reloads as 1.
            if (state == RELOAD) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (cfg_weight[i*WEIGHT_W +: WEIGHT_W] == '0)
                        credit[i] <= WEIGHT_W'(1);
                    else
                        credit[i] <= cfg_weight[i*WEIGHT_W +: WEIGHT_W];
                end
            end
            if (pkt_done) begin
                grant     <= '0;
                grant_idx <= '0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (IDX_W'(i) == grant_idx && credit[i] != '0)
                        credit[i] <= credit[i] - WEIGHT_W'(1);
                end
            end
        end
    end

`ifdef INGRESS_ARB_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn || stat_clear) begin
            stat_pkt_cnt   <= '0;
            stat_proto_err <= 1'b0;
        end else begin
            if (pkt_done) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (IDX_W'(i) == grant_idx)
                        stat_pkt_cnt[i*32 +: 32] <= stat_pkt_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if (m_fire && state != BUSY) stat_proto_err <= 1'b1;
        end
    end
`endif

endmodule
